roz_vram_scheduler: RTL and testbench

// Time-slot scheduler sharing the ROZ tilemap SRAM (12-bit word address, 16-bit data) between the
// 68000 CPU port and the ROZ video fetch pipeline. Sits between the ROZ chip CPU decode / fetch

---
 rtl/roz_vram_scheduler.sv | 176 +++++++++++++++++
 tb/tb_roz_vram_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roz_vram_scheduler.sv
// roz_vram_scheduler: slotted arbiter sharing the ROZ tilemap SRAM between the CPU port and
// the video fetch pipeline. One SRAM access per ce_13m slot; completion is pipelined with the
// next slot's address phase.
module roz_vram_scheduler #(
    parameter int unsigned              SlotBits = 3,
    parameter logic [(2**SlotBits)-1:0] CpuSlots = 8'b1000_1000,
    parameter bit                       Donate   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_13m_i,
    input  logic        hsync_n_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [11:0] cpu_addr_i,
    input  logic [15:0] cpu_din_i,
    input  logic        cpu_uds_n_i,
    input  logic        cpu_lds_n_i,
    output logic        cpu_busy_o,
    output logic        cpu_ack_o,
    output logic [15:0] cpu_dout_o,
    input  logic        vid_req_i,
    input  logic [11:0] vid_addr_i,
    output logic        vid_ack_o,
    output logic [15:0] vid_data_o,
    output logic [11:0] sa_o,
    input  logic [15:0] sd_i,
    output logic [15:0] sdout_o,
    output logic        weup_n_o,
    output logic        welo_n_o
);
    typedef enum logic [1:0] {AccIdle, AccCpu, AccVid} acc_e;

    acc_e                acc_q, acc_d;
    logic [SlotBits-1:0] slot_q, slot_d, slot_now;
    logic                hs_q, hs_d;
    logic                busy_q, busy_d;
    logic                req_we_q, req_we_d;
    logic [11:0]         req_addr_q, req_addr_d;
    logic [15:0]         req_din_q, req_din_d;
    logic                req_uds_q, req_uds_d, req_lds_q, req_lds_d;
    logic                acc_we_q, acc_we_d;
    logic [11:0]         sa_q, sa_d;
    logic [15:0]         sdout_q, sdout_d;
    logic                weup_q, weup_d, welo_q, welo_d;
    logic                cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
    logic [15:0]         cpu_dout_q, cpu_dout_d, vid_data_q, vid_data_d;
    logic                cpu_slot, cpu_pend;

    // Slot selection, grant decision, completion and CPU request latching.
    always_comb begin
        acc_d      = acc_q;
        slot_d     = slot_q;
        hs_d       = hs_q;
        busy_d     = busy_q;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_din_d  = req_din_q;
        req_uds_d  = req_uds_q;
        req_lds_d  = req_lds_q;
        acc_we_d   = acc_we_q;
        sa_d       = sa_q;
        sdout_d    = sdout_q;
        weup_d     = weup_q;
        welo_d     = welo_q;
        cpu_ack_d  = 1'b0;
        vid_ack_d  = 1'b0;
        cpu_dout_d = cpu_dout_q;
        vid_data_d = vid_data_q;

        // A sampled hsync rising edge renumbers the current slot as 0.
        slot_now = (!hs_q && hsync_n_i) ? '0 : slot_q;
        cpu_slot = CpuSlots[slot_now];
        // Latched but not yet granted; an in-flight CPU access must not be granted again.
        cpu_pend = busy_q && (acc_q != AccCpu);

        if (ce_13m_i) begin
            hs_d   = hsync_n_i;
            slot_d = slot_now + 1'b1;
            acc_d  = AccIdle;
            weup_d = 1'b1;
            welo_d = 1'b1;

            unique case (acc_q)
                AccCpu: begin
                    cpu_ack_d = 1'b1;
                    busy_d    = 1'b0;
                    if (!acc_we_q) cpu_dout_d = sd_i;
                end
                AccVid: begin
                    vid_ack_d  = 1'b1;
                    vid_data_d = sd_i;
                end
                default: ;
            endcase

            if (cpu_slot && cpu_pend) begin
                acc_d    = AccCpu;
                acc_we_d = req_we_q;
                sa_d     = req_addr_q;
                if (req_we_q) begin
                    sdout_d = req_din_q;
                    weup_d  = req_uds_q;
                    welo_d  = req_lds_q;
                end
            end else if (vid_req_i && (!cpu_slot || Donate)) begin
                acc_d = AccVid;
                sa_d  = vid_addr_i;
            end
        end

        // Completion only ever clears a busy flag that was already set, so no conflict here.
        if (cpu_req_i && !busy_q) begin
            busy_d     = 1'b1;
            req_we_d   = cpu_we_i;
            req_addr_d = cpu_addr_i;
            req_din_d  = cpu_din_i;
            req_uds_d  = cpu_uds_n_i;
            req_lds_d  = cpu_lds_n_i;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= AccIdle;
            slot_q     <= '0;
            hs_q       <= 1'b1;
            busy_q     <= 1'b0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_din_q  <= '0;
            req_uds_q  <= 1'b1;
            req_lds_q  <= 1'b1;
            acc_we_q   <= 1'b0;
            sa_q       <= '0;
            sdout_q    <= '0;
            weup_q     <= 1'b1;
            welo_q     <= 1'b1;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
            vid_data_q <= '0;
        end else begin
            acc_q      <= acc_d;
            slot_q     <= slot_d;
            hs_q       <= hs_d;
            busy_q     <= busy_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_din_q  <= req_din_d;
            req_uds_q  <= req_uds_d;
            req_lds_q  <= req_lds_d;
            acc_we_q   <= acc_we_d;
            sa_q       <= sa_d;
            sdout_q    <= sdout_d;
            weup_q     <= weup_d;
            welo_q     <= welo_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_ack_q  <= vid_ack_d;
            cpu_dout_q <= cpu_dout_d;
            vid_data_q <= vid_data_d;
        end
    end

    assign cpu_busy_o = busy_q;
    assign cpu_ack_o  = cpu_ack_q;
    assign cpu_dout_o = cpu_dout_q;
    assign vid_ack_o  = vid_ack_q;
    assign vid_data_o = vid_data_q;
    assign sa_o       = sa_q;
    assign sdout_o    = sdout_q;
    assign weup_n_o   = weup_q;
    assign welo_n_o   = welo_q;

endmodule

// File: tb/tb_roz_vram_scheduler.sv
// Bench for roz_vram_scheduler: directed scenarios plus random traffic, checked every clock
// against a slot-level reference model and a reference memory image.
module tb_roz_vram_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic hs_n = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_uds_n = 1'b1, cpu_lds_n = 1'b1;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic vid_req = 1'b0;
    logic [11:0] vid_addr = '0;

    logic cpu_busy, cpu_ack, vid_ack, weup_n, welo_n;
    logic [15:0] cpu_dout, vid_data, sdout, sd;
    logic [11:0] sa;
    // Second instance without donation, used only for slot-count comparison.
    logic cpu_busy_nd, cpu_ack_nd, vid_ack_nd, weup_n_nd, welo_n_nd;
    logic [15:0] cpu_dout_nd, vid_data_nd, sdout_nd, sd_nd;
    logic [11:0] sa_nd;

    logic [15:0] sram [4096];
    logic [15:0] ref_mem [4096];
    logic mem_loaded = 1'b0;

    roz_vram_scheduler dut (
        .clk(clk), .reset(reset), .ce_13m_i(ce), .hsync_n_i(hs_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
        .cpu_uds_n_i(cpu_uds_n), .cpu_lds_n_i(cpu_lds_n), .cpu_busy_o(cpu_busy),
        .cpu_ack_o(cpu_ack), .cpu_dout_o(cpu_dout), .vid_req_i(vid_req), .vid_addr_i(vid_addr),
        .vid_ack_o(vid_ack), .vid_data_o(vid_data), .sa_o(sa), .sd_i(sd), .sdout_o(sdout),
        .weup_n_o(weup_n), .welo_n_o(welo_n)
    );

    roz_vram_scheduler #(.Donate(1'b0)) dut_nd (
        .clk(clk), .reset(reset), .ce_13m_i(ce), .hsync_n_i(hs_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
        .cpu_uds_n_i(cpu_uds_n), .cpu_lds_n_i(cpu_lds_n), .cpu_busy_o(cpu_busy_nd),
        .cpu_ack_o(cpu_ack_nd), .cpu_dout_o(cpu_dout_nd), .vid_req_i(vid_req),
        .vid_addr_i(vid_addr), .vid_ack_o(vid_ack_nd), .vid_data_o(vid_data_nd), .sa_o(sa_nd),
        .sd_i(sd_nd), .sdout_o(sdout_nd), .weup_n_o(weup_n_nd), .welo_n_o(welo_n_nd)
    );

    always #5 clk = ~clk;

    assign sd    = sram[sa];
    assign sd_nd = sram[sa_nd];

    function automatic logic [15:0] init_word(input int i);
        logic [31:0] h;
        if (i == 32'h123) return 16'hBEEF;
        if (i == 32'h010) return 16'h1234;
        h = i * 40503;
        return h[15:0] ^ 16'hC3A5;
    endfunction

    // SRAM pin model: byte-lane writes commit at the end of each slot.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (ce && !reset) begin
            if (!weup_n) sram[sa][15:8] <= sdout[15:8];
            if (!welo_n) sram[sa][7:0] <= sdout[7:0];
        end
    end

    int n_checks = 0, n_fail = 0;
    int clk_cnt = 0;
    bit was_ce;
    int n_cpu_ack, n_vid_ack, n_vid_ack_nd, n_welo_low, n_weup_low, n_watch;
    logic [11:0] watch_addr = 12'hFFF;
    logic [7:0] cpu_mask = 8'b1000_1000;

    // Reference model: next slot number, pending CPU request, access occupying the current slot.
    int m_slot;
    bit m_prev_hs = 1'b1, m_busy, m_pend;
    bit p_we, p_uds, p_lds;
    logic [11:0] p_addr;
    logic [15:0] p_din;
    int f_kind;  // 0 idle, 1 cpu, 2 video
    bit f_we, f_uds, f_lds;
    logic [11:0] f_addr;
    logic [15:0] f_din;
    bit e_cpu_ack, e_vid_ack, e_weup = 1'b1, e_welo = 1'b1;
    logic [11:0] e_sa = '0;
    logic [15:0] e_dout = '0, e_vdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit old_busy;
        int s;
        old_busy  = m_busy;
        e_cpu_ack = 1'b0;
        e_vid_ack = 1'b0;
        if (reset) begin
            m_slot = 0; m_prev_hs = 1'b1; m_busy = 1'b0; m_pend = 1'b0; f_kind = 0;
            e_sa = '0; e_weup = 1'b1; e_welo = 1'b1; e_dout = '0; e_vdata = '0;
            return;
        end
        if (ce) begin
            if (f_kind == 1) begin
                e_cpu_ack = 1'b1;
                m_busy    = 1'b0;
                if (f_we) begin
                    if (!f_uds) ref_mem[f_addr][15:8] = f_din[15:8];
                    if (!f_lds) ref_mem[f_addr][7:0] = f_din[7:0];
                end else begin
                    e_dout = ref_mem[f_addr];
                end
            end else if (f_kind == 2) begin
                e_vid_ack = 1'b1;
                e_vdata   = ref_mem[f_addr];
            end
            s = (!m_prev_hs && hs_n) ? 0 : m_slot;
            m_prev_hs = hs_n;
            m_slot = (s + 1) % 8;
            f_kind = 0;
            e_weup = 1'b1;
            e_welo = 1'b1;
            if (cpu_mask[s] && m_pend) begin
                f_kind = 1; m_pend = 1'b0;
                f_we = p_we; f_addr = p_addr; f_din = p_din; f_uds = p_uds; f_lds = p_lds;
                e_sa = p_addr;
                if (p_we) begin
                    e_weup = p_uds;
                    e_welo = p_lds;
                end
            end else if (vid_req) begin
                f_kind = 2; f_addr = vid_addr; e_sa = vid_addr;
            end
        end
        if (cpu_req && !old_busy) begin
            m_busy = 1'b1; m_pend = 1'b1;
            p_we = cpu_we; p_addr = cpu_addr; p_din = cpu_din; p_uds = cpu_uds_n; p_lds = cpu_lds_n;
        end
    endtask

    task automatic check_all();
        check_eq("cpu_ack", cpu_ack, e_cpu_ack);
        check_eq("vid_ack", vid_ack, e_vid_ack);
        check_eq("cpu_busy", cpu_busy, m_busy);
        check_eq("sa", sa, e_sa);
        check_eq("weup_n", weup_n, e_weup);
        check_eq("welo_n", welo_n, e_welo);
        check_eq("cpu_dout", cpu_dout, e_dout);
        check_eq("vid_data", vid_data, e_vdata);
        if (f_kind == 1 && f_we) check_eq("sdout", sdout, f_din);
    endtask

    task automatic step();
        @(posedge clk);
        was_ce = ce;
        model_update();
        #1;
        check_all();
        if (cpu_ack) n_cpu_ack++;
        if (vid_ack) n_vid_ack++;
        if (vid_ack_nd) n_vid_ack_nd++;
        if (!welo_n) n_welo_low++;
        if (!weup_n) n_weup_low++;
        if (sa == watch_addr) n_watch++;
        cpu_req = 1'b0;
        if (vid_ack) vid_addr = 12'($urandom);
        clk_cnt++;
        ce = (clk_cnt % 4) == 3;
    endtask

    task automatic clear_counts();
        n_cpu_ack = 0; n_vid_ack = 0; n_vid_ack_nd = 0;
        n_welo_low = 0; n_weup_low = 0; n_watch = 0;
    endtask

    // Leaves reset released with the next edge a non-ce edge, so slot 0 is still ahead.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        while (ce) step();
        reset = 1'b0;
    endtask

    task automatic cpu_issue(input bit we, input logic [11:0] a, input logic [15:0] d,
                             input bit u, input bit l);
        cpu_we = we; cpu_addr = a; cpu_din = d; cpu_uds_n = u; cpu_lds_n = l;
        cpu_req = 1'b1;
        step();
    endtask

    task automatic wait_cpu_ack(input string tag, output int n_ce);
        n_ce = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (was_ce) n_ce++;
            if (cpu_ack) break;
        end
        check_eq(tag, cpu_ack, 1);
    endtask

    initial begin
        int n_ce;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);

        // Reset state and CPU read latency from slot 0.
        do_reset();
        check_eq("rst_sa", sa, 0);
        check_eq("rst_dout", cpu_dout, 0);
        check_eq("rst_we", {weup_n, welo_n}, 2'b11);
        cpu_issue(1'b0, 12'h123, 16'h0, 1'b0, 1'b0);
        wait_cpu_ack("t1_ack", n_ce);
        check_eq("t1_ce_to_ack", n_ce, 5);
        check_eq("t1_dout", cpu_dout, 16'hBEEF);

        // Lower-byte write: one slot of WELOn, then read back merged word.
        clear_counts();
        cpu_issue(1'b1, 12'h010, 16'h5A5A, 1'b1, 1'b0);
        wait_cpu_ack("t2_ack", n_ce);
        check_eq("t2_welo_clks", n_welo_low, 4);
        check_eq("t2_weup_clks", n_weup_low, 0);
        cpu_issue(1'b0, 12'h010, 16'h0, 1'b0, 1'b0);
        wait_cpu_ack("t2_rd_ack", n_ce);
        check_eq("t2_readback", cpu_dout, 16'h125A);

        // Second request while busy is dropped.
        clear_counts();
        watch_addr = 12'h0B0;
        cpu_issue(1'b0, 12'h0A0, 16'h0, 1'b0, 1'b0);
        cpu_issue(1'b0, 12'h0B0, 16'h0, 1'b0, 1'b0);
        repeat (80) step();
        check_eq("t4_acks", n_cpu_ack, 1);
        check_eq("t4_second_addr_seen", n_watch, 0);
        watch_addr = 12'hFFF;

        // Hsync realign at slot 5 with video in flight.
        vid_req = 1'b1;
        hs_n = 1'b0;
        repeat (8) step();
        for (int k = 0; k < 40 && !(m_slot == 5 && ce); k++) step();
        hs_n = 1'b1;
        cpu_issue(1'b0, 12'h123, 16'h0, 1'b0, 1'b0);
        check_eq("t5_inflight_vid_ack", vid_ack, 1);
        wait_cpu_ack("t5_ack", n_ce);
        check_eq("t5_ce_to_ack", n_ce, 4);
        check_eq("t5_dout", cpu_dout, 16'hBEEF);
        vid_req = 1'b0;
        repeat (8) step();

        // Reset during a write slot.
        clear_counts();
        cpu_issue(1'b1, 12'h200, 16'hFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 60 && welo_n; k++) step();
        check_eq("t6_write_started", welo_n, 0);
        reset = 1'b1;
        step();
        check_eq("t6_we_after_rst", {weup_n, welo_n}, 2'b11);
        check_eq("t6_busy_after_rst", cpu_busy, 0);
        reset = 1'b0;
        repeat (40) step();
        check_eq("t6_no_ack", n_cpu_ack, 0);
        cpu_issue(1'b0, 12'h200, 16'h0, 1'b0, 1'b0);
        wait_cpu_ack("t6_rd_ack", n_ce);
        check_eq("t6_mem_untouched", cpu_dout, init_word(32'h200));

        // Video bandwidth with and without donation.
        vid_req = 1'b1;
        repeat (16) step();
        clear_counts();
        repeat (32) step();
        check_eq("t3_vid_acks_donate", n_vid_ack, 8);
        check_eq("t3_vid_acks_nodonate", n_vid_ack_nd, 6);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) vid_req = ~vid_req;
            if ($urandom_range(0, 39) == 0) hs_n = ~hs_n;
            if ($urandom_range(0, 4) == 0) begin
                cpu_we = 1'($urandom); cpu_addr = 12'($urandom); cpu_din = 16'($urandom);
                cpu_uds_n = 1'($urandom); cpu_lds_n = 1'($urandom);
                cpu_req = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
